uart_tx_peripheral: RTL and testbench
=====================================

Name: uart_tx_peripheral

Overview:
- Byte-oriented UART transmitter; the transmit end of the serial link whose receive end drives the 7-segment display peripheral.
- Accepts bytes over a valid/ready handshake into an internal FIFO.
- Serializes each byte as start, 8 data bits LSB first, optional parity, then stop bits.
- Frame format and bit rate are set at elaboration.

Parameters:
- PARITY, 1, 1 = parity bit present, 0 = absent.
- PARITY_TYPE, 0, 0 = even, 1 = odd (ignored when PARITY=0).
- NSTOP, 1, stop bits per frame; legal values 1 or 2.
- FCLK_HZ, 50e6, clk frequency in Hz.
- FUART_HZ, 115200, bit rate in Hz.
- FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH entries.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO can accept; transfer occurs on a rising clk edge with tx_valid && tx_ready.
- utx  output  1  serial line; idles high.
- busy  output  1  FSM not IDLE, or FIFO not empty.
- fifo_level  output  FIFO_ADDR_WIDTH+1  entries currently stored.

Behaviour:
- Design: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: utx=1, tx_ready=1, busy=0, fifo_level=0, FSM=IDLE, FIFO flushed, baud counter=0.
- BAUD_DIV = round(FCLK_HZ/FUART_HZ), checked at elaboration to be >= 2 (50e6/115200 gives 434). Every bit lasts exactly BAUD_DIV clk cycles.
- FIFO: synchronous, first-in first-out.
  - tx_ready = (fifo_level < 2**FIFO_ADDR_WIDTH), registered-equivalent and valid in the cycle it is sampled.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - A push is never lost while tx_ready=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when FIFO is non-empty. The pop happens on the same edge; the byte is loaded into the shift register and utx=0 drives from that edge.
  - Latency: when idle with FIFO empty, the start bit begins on the 2nd rising edge after the accepting edge.
  - START -> DATA after BAUD_DIV cycles.
  - DATA shifts LSB first for 8 bit periods, using a bit counter 0..7.
  - DATA -> PARITY if PARITY=1, else -> STOP.
  - Parity bit: PARITY_TYPE=0 gives the XOR of the data bits; PARITY_TYPE=1 gives its complement.
  - STOP drives utx=1 for NSTOP*BAUD_DIV cycles.
  - After the last stop cycle: if the FIFO is non-empty, pop and go directly to START with zero idle gap; else go to IDLE.
- utx is driven from a flop, so the line never glitches.
- tx_data is sampled only at push; later changes do not affect queued bytes.
- Reset asserted mid-frame: utx goes to 1 asynchronously, the frame is aborted, the FIFO is flushed and busy=0. After reset release, transmission resumes only on new pushes.
- FIFO full while transmitting: tx_ready=0 until the next pop. The pop occurs at the IDLE/STOP->START boundary.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- Defined: adds port cts_n (input, 1 bit, asynchronous to clk, active-low clear-to-send).
  - cts_n is synchronized with a 2-flop synchronizer.
  - A new frame (the pop and transition to START) starts only when synchronized cts_n=0.
  - A frame already started always completes regardless of cts_n.
  - While blocked, the FSM stays IDLE, utx=1, and busy=1 if the FIFO is non-empty.
- Undefined: no cts_n port; frames start whenever the FIFO is non-empty.

Test Plan:
- Basic frame: FCLK_HZ=1e6, FUART_HZ=100e3 (BAUD_DIV=10), PARITY=1 even, NSTOP=1; push 0xA5.
  -> Start bit low begins 2 cycles after accept.
  -> Bits 1,0,1,0,0,1,0,1, then parity 0, then stop 1; 110 cycles total.
  -> busy then drops to 0.
- Odd parity, no parity, 2 stop bits:
  -> 0xA5 with PARITY_TYPE=1 gives parity bit 1.
  -> PARITY=0, NSTOP=2, push 0x00 gives a frame of 1+8+2=11 bits = 110 cycles, with utx high for the final 20 cycles.
- Back-to-back: push 0x55 then 0x0F on consecutive cycles.
  -> Second start bit begins the cycle after the first stop period ends, with no gap.
  -> Line sequence is correct.
- FIFO full: FIFO_ADDR_WIDTH=2, hold tx_valid=1 with bytes 0x01..0x06.
  -> 0x01 is popped into the shifter; 0x02..0x05 fill the FIFO (fifo_level=4) and tx_ready=0.
  -> 0x06 is accepted only on the edge after 0x02 is popped.
  -> All six bytes appear on utx in order.
- Reset mid-frame: assert rst during data bit 3 of 0x3C with 2 more bytes queued.
  -> utx=1 immediately; fifo_level=0, busy=0.
  -> No further frames are sent after release until a new push.
- With UART_TX_CTS_EN: cts_n=1, push 0x7E.
  -> utx stays 1 and busy=1.
  -> Driving cts_n=0 starts the frame 3 cycles later (2 sync cycles plus 1 pop).
  -> Raising cts_n mid-frame does not truncate the frame.

Source files
------------

// File: rtl/uart_tx_peripheral.sv
// ---------------------------------------------------------------------------
// uart_tx_peripheral
//   Byte-oriented UART transmitter. Bytes are pushed over a valid/ready
//   handshake into a FIFO, then serialized as:
//   start bit, 8 data bits LSB first, optional parity bit, NSTOP stop bits.
//   Frame format and bit rate are fixed at elaboration.
//
// Optional feature (macro UART_TX_CTS_EN):
//   Adds the cts_n input, an asynchronous active-low clear-to-send.
//   It passes through a 2-flop synchronizer. A new frame starts only while
//   the synchronized cts_n is low. A frame that has already started always
//   runs to completion.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   cts_n       clear-to-send, active low (only with UART_TX_CTS_EN)
//   tx_data     byte to send
//   tx_valid    tx_data valid
//   tx_ready    FIFO can accept (transfer on clk edge with valid && ready)
//   utx         serial line, idles high, driven from a flop
//   busy        FSM not idle or FIFO not empty
//   fifo_level  entries currently held in the FIFO
// ---------------------------------------------------------------------------
module uart_tx_peripheral #(
  parameter int  PARITY          = 1,
  parameter int  PARITY_TYPE     = 0,
  parameter int  NSTOP           = 1,
  parameter real FCLK_HZ         = 50.0e6,
  parameter real FUART_HZ        = 115200.0,
  parameter int  FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef UART_TX_CTS_EN
  input  logic                     cts_n,
`endif
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     utx,
  output logic                     busy,
  output logic [FIFO_ADDR_WIDTH:0] fifo_level
);

  localparam int   AW       = FIFO_ADDR_WIDTH;
  localparam int   DEPTH    = 1 << AW;
  localparam int   BAUD_DIV = $rtoi(FCLK_HZ / FUART_HZ + 0.5);
  localparam int   STOP_CYC = NSTOP * BAUD_DIV;
  localparam int   CW       = $clog2(STOP_CYC);
  localparam logic PAR_ODD  = (PARITY_TYPE != 0);

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_peripheral: BAUD_DIV must be >= 2");
    end
    if (NSTOP != 1 && NSTOP != 2) begin : g_bad_nstop
      $error("uart_tx_peripheral: NSTOP must be 1 or 2");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FIFO: RAM array with a registered read port
  // -------------------------------------------------------------------------
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_rd_data;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_nonempty_d;
  logic          w_push;
  logic          w_pop;
  logic          w_avail;
  logic          w_cts_ok;
  logic          w_launch;

  // The level never exceeds DEPTH, so its MSB is set exactly when full.
  assign tx_ready = ~r_level[AW];
  assign w_push   = tx_valid & tx_ready;

  // A freshly written entry reaches r_rd_data one edge after the write.
  // r_nonempty_d delays the "available" view by one cycle so the FSM
  // never pops before the read register holds the head entry.
  assign w_avail  = r_nonempty_d & (r_level != '0);
  assign w_launch = w_avail & w_cts_ok;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
    r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_nonempty_d <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      r_nonempty_d <= (r_level != '0);
    end
  end

  // -------------------------------------------------------------------------
  // Clear-to-send gating
  // -------------------------------------------------------------------------
`ifdef UART_TX_CTS_EN
  logic r_cts_meta;
  logic r_cts_sync;

  // Both stages reset high so no frame can start before cts_n is
  // actually observed low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_cts_ok = ~r_cts_sync;
`else
  assign w_cts_ok = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_baud_cnt;
  logic [CW-1:0] w_baud_cnt_next;
  logic [2:0]    r_bit_cnt;
  logic [2:0]    w_bit_cnt_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_parity;
  logic          w_parity_next;
  logic          r_utx;
  logic          w_utx_next;
  logic          w_bit_end;
  logic          w_stop_end;

  assign w_bit_end  = (r_baud_cnt == CW'(BAUD_DIV - 1));
  assign w_stop_end = (r_baud_cnt == CW'(STOP_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_utx      <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_utx      <= w_utx_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt + CW'(1);
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_parity_next   = r_parity;
    w_utx_next      = r_utx;
    w_pop           = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_cnt_next = '0;
        w_utx_next      = 1'b1;
        if (w_launch) begin
          w_pop           = 1'b1;
          w_state_next    = S_START;
          w_shift_next    = r_rd_data;
          w_parity_next   = (^r_rd_data) ^ PAR_ODD;
          w_bit_cnt_next  = '0;
          w_utx_next      = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next    = S_DATA;
          w_baud_cnt_next = '0;
          w_utx_next      = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          if (r_bit_cnt == 3'd7) begin
            if (PARITY != 0) begin
              w_state_next = S_PARITY;
              w_utx_next   = r_parity;
            end else begin
              w_state_next = S_STOP;
              w_utx_next   = 1'b1;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_utx_next     = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next    = S_STOP;
          w_baud_cnt_next = '0;
          w_utx_next      = 1'b1;
        end
      end
      S_STOP: begin
        // One counter run covers all stop bits.
        if (w_stop_end) begin
          w_baud_cnt_next = '0;
          if (w_launch) begin
            // Next byte starts with zero idle gap.
            w_pop          = 1'b1;
            w_state_next   = S_START;
            w_shift_next   = r_rd_data;
            w_parity_next  = (^r_rd_data) ^ PAR_ODD;
            w_bit_cnt_next = '0;
            w_utx_next     = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_utx_next   = 1'b1;
          end
        end
      end
      default: begin
        w_state_next    = S_IDLE;
        w_baud_cnt_next = '0;
        w_utx_next      = 1'b1;
      end
    endcase
  end

  assign utx        = r_utx;
  assign busy       = (r_state != S_IDLE) | (r_level != '0);
  assign fifo_level = r_level;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_peripheral
//   Directed testbench for uart_tx_peripheral. All instances use
//   BAUD_DIV = 10 (1 MHz clock, 100 kHz bit rate):
//     0: even parity, 1 stop, depth 16
//     1: odd parity,  1 stop, depth 16
//     2: no parity,   2 stop, depth 16
//     3: even parity, 1 stop, depth 4
//   All inputs are driven and all outputs sampled on the falling clk edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_peripheral;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_s     [4];
  logic       v_s     [4];
  logic       ready_s [4];
  logic       utx_s   [4];
  logic       busy_s  [4];
  logic [4:0] lvl_a, lvl_b, lvl_c;
  logic [2:0] lvl_d;
`ifdef UART_TX_CTS_EN
  logic       cts_s   [4];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_peripheral #(.PARITY(1), .PARITY_TYPE(0), .NSTOP(1), .FCLK_HZ(1.0e6),
                       .FUART_HZ(100.0e3), .FIFO_ADDR_WIDTH(4)) u_a (
    .clk(clk), .rst(rst),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_s[0]),
`endif
    .tx_data(d_s[0]), .tx_valid(v_s[0]), .tx_ready(ready_s[0]),
    .utx(utx_s[0]), .busy(busy_s[0]), .fifo_level(lvl_a));

  uart_tx_peripheral #(.PARITY(1), .PARITY_TYPE(1), .NSTOP(1), .FCLK_HZ(1.0e6),
                       .FUART_HZ(100.0e3), .FIFO_ADDR_WIDTH(4)) u_b (
    .clk(clk), .rst(rst),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_s[1]),
`endif
    .tx_data(d_s[1]), .tx_valid(v_s[1]), .tx_ready(ready_s[1]),
    .utx(utx_s[1]), .busy(busy_s[1]), .fifo_level(lvl_b));

  uart_tx_peripheral #(.PARITY(0), .PARITY_TYPE(0), .NSTOP(2), .FCLK_HZ(1.0e6),
                       .FUART_HZ(100.0e3), .FIFO_ADDR_WIDTH(4)) u_c (
    .clk(clk), .rst(rst),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_s[2]),
`endif
    .tx_data(d_s[2]), .tx_valid(v_s[2]), .tx_ready(ready_s[2]),
    .utx(utx_s[2]), .busy(busy_s[2]), .fifo_level(lvl_c));

  uart_tx_peripheral #(.PARITY(1), .PARITY_TYPE(0), .NSTOP(1), .FCLK_HZ(1.0e6),
                       .FUART_HZ(100.0e3), .FIFO_ADDR_WIDTH(2)) u_d (
    .clk(clk), .rst(rst),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_s[3]),
`endif
    .tx_data(d_s[3]), .tx_valid(v_s[3]), .tx_ready(ready_s[3]),
    .utx(utx_s[3]), .busy(busy_s[3]), .fifo_level(lvl_d));

  // Single-cycle push on instance k; returns on the falling edge after
  // the accepting rising edge.
  task automatic push(input int k, input logic [7:0] b);
    d_s[k] = b;
    v_s[k] = 1'b1;
    @(negedge clk);
    v_s[k] = 1'b0;
  endtask

  // Waits for a start bit on instance k (lat = falling edges waited), then
  // samples nbits bit periods at mid-bit. Returns at the last mid-bit sample.
  task automatic sample_frame(input int k, input int nbits,
                              output logic [15:0] bits, output int lat);
    lat  = 0;
    bits = '0;
    while (utx_s[k] !== 1'b0 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (utx_s[k] === 1'b0) begin
      repeat (5) @(negedge clk);
      bits[0] = utx_s[k];
      for (int i = 1; i < nbits; i++) begin
        repeat (10) @(negedge clk);
        bits[i] = utx_s[k];
      end
    end else begin
      bits = '1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (utx_s[0] !== 1'b1 || ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || lvl_a !== 5'd0)
      begin n_fail++; $display("FAIL reset_a: utx=%b ready=%b busy=%b level=%0d, required 1 1 0 0",
                               utx_s[0], ready_s[0], busy_s[0], lvl_a); end
    n_checks++;
    if (utx_s[3] !== 1'b1 || ready_s[3] !== 1'b1 || busy_s[3] !== 1'b0 || lvl_d !== 3'd0)
      begin n_fail++; $display("FAIL reset_d: utx=%b ready=%b busy=%b level=%0d, required 1 1 0 0",
                               utx_s[3], ready_s[3], busy_s[3], lvl_d); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    logic [15:0] bits;
    int lat;
    push(0, 8'hA5);
    sample_frame(0, 11, bits, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d required 2", lat); end
    n_checks++;
    if (bits[10:0] !== 11'b1_0_10100101_0)
      begin n_fail++; $display("FAIL basic_bits: got %b required %b", bits[10:0], 11'b1_0_10100101_0); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy_s[0] !== 1'b1 || utx_s[0] !== 1'b1)
      begin n_fail++; $display("FAIL basic_stop_end: busy=%b utx=%b required 1 1", busy_s[0], utx_s[0]); end
    @(negedge clk);
    n_checks++;
    if (busy_s[0] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %b required 0", busy_s[0]); end
    $display("test_basic_frame: A5 bits=%b lat=%0d", bits[10:0], lat);
  endtask

  task automatic test_odd_parity();
    logic [15:0] bits;
    int lat;
    push(1, 8'hA5);
    sample_frame(1, 11, bits, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL odd_latency: got %0d required 2", lat); end
    n_checks++;
    if (bits[10:0] !== 11'b1_1_10100101_0)
      begin n_fail++; $display("FAIL odd_bits: got %b required %b", bits[10:0], 11'b1_1_10100101_0); end
    repeat (10) @(negedge clk);
    $display("test_odd_parity: A5 bits=%b", bits[10:0]);
  endtask

  task automatic test_no_parity_two_stop();
    logic [15:0] bits;
    int lat;
    push(2, 8'h00);
    sample_frame(2, 9, bits, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL np2s_latency: got %0d required 2", lat); end
    n_checks++;
    if (bits[8:0] !== 9'b0) begin n_fail++; $display("FAIL np2s_bits: got %b required 000000000", bits[8:0]); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (utx_s[2] !== 1'b0) begin n_fail++; $display("FAIL np2s_last_data: got %b required 0", utx_s[2]); end
    @(negedge clk);
    n_checks++;
    if (utx_s[2] !== 1'b1) begin n_fail++; $display("FAIL np2s_stop_begin: got %b required 1", utx_s[2]); end
    repeat (19) @(negedge clk);
    n_checks++;
    if (utx_s[2] !== 1'b1 || busy_s[2] !== 1'b1)
      begin n_fail++; $display("FAIL np2s_stop_end: utx=%b busy=%b required 1 1", utx_s[2], busy_s[2]); end
    @(negedge clk);
    n_checks++;
    if (busy_s[2] !== 1'b0) begin n_fail++; $display("FAIL np2s_busy_drop: got %b required 0", busy_s[2]); end
    $display("test_no_parity_two_stop: 00 bits=%b", bits[8:0]);
  endtask

  task automatic test_back_to_back();
    logic [15:0] b1, b2;
    int l1, l2;
    push(0, 8'h55);
    push(0, 8'h0F);
    sample_frame(0, 11, b1, l1);
    sample_frame(0, 11, b2, l2);
    n_checks++;
    if (l1 !== 1) begin n_fail++; $display("FAIL b2b_latency1: got %0d required 1", l1); end
    n_checks++;
    if (l2 !== 5) begin n_fail++; $display("FAIL b2b_gap: got %0d required 5", l2); end
    n_checks++;
    if (b1[10:0] !== 11'b1_0_01010101_0)
      begin n_fail++; $display("FAIL b2b_bits1: got %b required %b", b1[10:0], 11'b1_0_01010101_0); end
    n_checks++;
    if (b2[10:0] !== 11'b1_0_00001111_0)
      begin n_fail++; $display("FAIL b2b_bits2: got %b required %b", b2[10:0], 11'b1_0_00001111_0); end
    repeat (10) @(negedge clk);
    $display("test_back_to_back: 55 bits=%b 0F bits=%b gap=%0d", b1[10:0], b2[10:0], l2);
  endtask

  task automatic test_fifo_full();
    logic [10:0] exp6 [6];
    logic [15:0] fb [6];
    int fl [6];
    int acc [7];
    int c, b;
    logic will;
    exp6[0] = 11'b1_1_00000001_0;
    exp6[1] = 11'b1_1_00000010_0;
    exp6[2] = 11'b1_0_00000011_0;
    exp6[3] = 11'b1_1_00000100_0;
    exp6[4] = 11'b1_0_00000101_0;
    exp6[5] = 11'b1_0_00000110_0;
    for (int i = 0; i < 7; i++) acc[i] = -1;
    fork
      begin
        b = 1;
        c = 0;
        v_s[3] = 1'b1;
        while (b <= 6 && c < 400) begin
          d_s[3] = 8'(b);
          will = ready_s[3];
          if (c == 5) begin
            n_checks++;
            if (lvl_d !== 3'd4 || ready_s[3] !== 1'b0)
              begin n_fail++; $display("FAIL full_level: level=%0d ready=%b required 4 0", lvl_d, ready_s[3]); end
          end
          @(negedge clk);
          if (will) begin
            acc[b] = c;
            b++;
          end
          c++;
        end
        v_s[3] = 1'b0;
      end
      begin
        for (int f = 0; f < 6; f++) sample_frame(3, 11, fb[f], fl[f]);
      end
    join
    n_checks++;
    if (acc[5] !== 4) begin n_fail++; $display("FAIL full_accept5: edge %0d required 4", acc[5]); end
    n_checks++;
    if (acc[6] !== 113) begin n_fail++; $display("FAIL full_accept6: edge %0d required 113", acc[6]); end
    for (int f = 0; f < 6; f++) begin
      n_checks++;
      if (fb[f][10:0] !== exp6[f] || fl[f] !== ((f == 0) ? 3 : 5))
        begin n_fail++; $display("FAIL full_frame%0d: bits=%b lat=%0d required %b lat=%0d",
                                 f, fb[f][10:0], fl[f], exp6[f], (f == 0) ? 3 : 5); end
      $display("test_fifo_full: frame %0d bits=%b lat=%0d", f, fb[f][10:0], fl[f]);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy_s[3] !== 1'b0 || lvl_d !== 3'd0)
      begin n_fail++; $display("FAIL full_drain: busy=%b level=%0d required 0 0", busy_s[3], lvl_d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits;
    int lat, bad;
    push(0, 8'h3C);
    push(0, 8'h11);
    push(0, 8'h22);
    n_checks++;
    if (utx_s[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_start: got %b required 0", utx_s[0]); end
    repeat (25) @(negedge clk);
    n_checks++;
    if (utx_s[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_bit1: got %b required 0", utx_s[0]); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (utx_s[0] !== 1'b1 || lvl_a !== 5'd2)
      begin n_fail++; $display("FAIL rmid_bit3: utx=%b level=%0d required 1 2", utx_s[0], lvl_a); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (utx_s[0] !== 1'b1 || lvl_a !== 5'd0 || busy_s[0] !== 1'b0)
      begin n_fail++; $display("FAIL rmid_async: utx=%b level=%0d busy=%b required 1 0 0",
                               utx_s[0], lvl_a, busy_s[0]); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (utx_s[0] !== 1'b1 || busy_s[0] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rmid_quiet: %0d active cycles required 0", bad); end
    push(0, 8'h81);
    sample_frame(0, 11, bits, lat);
    n_checks++;
    if (lat !== 2 || bits[10:0] !== 11'b1_0_10000001_0)
      begin n_fail++; $display("FAIL rmid_resume: bits=%b lat=%0d required %b lat=2",
                               bits[10:0], lat, 11'b1_0_10000001_0); end
    repeat (10) @(negedge clk);
    $display("test_reset_mid_frame: resumed 81 bits=%b", bits[10:0]);
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    logic [15:0] bits;
    int lat;
    cts_s[0] = 1'b1;
    push(0, 8'h7E);
    repeat (20) @(negedge clk);
    n_checks++;
    if (utx_s[0] !== 1'b1 || busy_s[0] !== 1'b1 || lvl_a !== 5'd1)
      begin n_fail++; $display("FAIL cts_blocked: utx=%b busy=%b level=%0d required 1 1 1",
                               utx_s[0], busy_s[0], lvl_a); end
    cts_s[0] = 1'b0;
    fork
      sample_frame(0, 11, bits, lat);
      begin
        repeat (40) @(negedge clk);
        cts_s[0] = 1'b1;
      end
    join
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL cts_latency: got %0d required 3", lat); end
    n_checks++;
    if (bits[10:0] !== 11'b1_0_01111110_0)
      begin n_fail++; $display("FAIL cts_bits: got %b required %b", bits[10:0], 11'b1_0_01111110_0); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy_s[0] !== 1'b0) begin n_fail++; $display("FAIL cts_busy_drop: got %b required 0", busy_s[0]); end
    cts_s[0] = 1'b0;
    $display("test_cts: 7E bits=%b lat=%0d", bits[10:0], lat);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_s[i] = 8'h00;
      v_s[i] = 1'b0;
`ifdef UART_TX_CTS_EN
      cts_s[i] = 1'b0;
`endif
    end
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_odd_parity();
    test_no_parity_two_stop();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
